// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead adder slice with group P/G and a registered sum/carry copy
module cla_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       pg,
    output logic       gg,
    output logic [3:0] sum_q,
    output logic       cout_q
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;
    logic [3:0] r_sum;
    logic       r_cout;
    assign w_p = a ^ b;
    assign w_g = a & b;
    // every carry is a flat sum of products of p/g/cin, so no bit waits on its neighbour
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign sum  = w_p ^ w_c;
    assign pg   = &w_p;
    assign gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign cout = gg | (pg & cin);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum  <= 4'b0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= sum;
            r_cout <= cout;
        end
    end
    assign sum_q  = r_sum;
    assign cout_q = r_cout;
endmodule

// File: tb/tb_cla_4bit.sv
// tb_cla_4bit: directed and exhaustive checks of cla_4bit plus a 16-bit chain of four slices
module tb_cla_4bit;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a, b;
    logic        cin;
    logic [3:0]  sum, sum_q;
    logic        cout, cout_q, pg, gg;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] ca, cb, csum;
    logic        ccin;
    logic [4:0]  ch;
    logic [3:0]  cpg, cgg, ccq;
    logic [15:0] csq;

    always #5 clk = ~clk;

    cla_4bit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .pg(pg), .gg(gg),
        .sum_q(sum_q), .cout_q(cout_q)
    );

    assign ch[0] = ccin;
    for (genvar i = 0; i < 4; i++) begin : g_chain
        cla_4bit u_slice (
            .clk(clk), .rst(rst), .a(ca[4*i +: 4]), .b(cb[4*i +: 4]), .cin(ch[i]),
            .sum(csum[4*i +: 4]), .cout(ch[i+1]), .pg(cpg[i]), .gg(cgg[i]),
            .sum_q(csq[4*i +: 4]), .cout_q(ccq[i])
        );
    end

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] e;
        rst = 1'b0; a = 4'd9; b = 4'd9; cin = 1'b0;
        ca = '0; cb = '0; ccin = 1'b0;
        #1;
        chk("rst_sumq_t1", sum_q, 0);
        chk("rst_coutq_t1", cout_q, 0);
        chk("rst_comb_sum", sum, 2);
        chk("rst_comb_cout", cout, 1);
        #7;
        chk("rst_regs_t8", {cout_q, sum_q}, 0);
        #7;
        chk("rst_regs_t15", {cout_q, sum_q}, 0);
        chk("rst_comb_t15", {cout, sum}, 5'h12);
        #2 rst = 1'b1;

        @(negedge clk) a = 14; b = 1; cin = 0;
        #1 chk("add14_1_0", {cout, sum}, 15);
        @(posedge clk) #1 chk("add14_1_0_q", {cout_q, sum_q}, 15);
        @(negedge clk) a = 14; b = 1; cin = 1;
        #1 chk("add14_1_1", {cout, sum}, 16);
        @(posedge clk) #1 chk("add14_1_1_q", {cout_q, sum_q}, 16);
        @(negedge clk) a = 15; b = 1; cin = 0;
        #1 chk("add15_1_0", {cout, sum}, 16);
        @(posedge clk) #1 chk("add15_1_0_q", {cout_q, sum_q}, 16);
        @(negedge clk) a = 0; b = 0; cin = 1;
        #1 chk("add0_0_1", {cout, sum}, 1);
        @(posedge clk) #1 chk("add0_0_1_q", {cout_q, sum_q}, 1);

        @(negedge clk) a = 5; b = 10; cin = 0;
        #1 chk("grp5_10_pg", pg, 1);
        chk("grp5_10_gg", gg, 0);
        chk("grp5_10_c0", {cout, sum}, 15);
        cin = 1;
        #1 chk("grp5_10_c1", {cout, sum}, 16);
        a = 8; b = 8; cin = 0;
        #1 chk("grp8_8_pgg", {pg, gg}, 1);
        chk("grp8_8_c0", cout, 1);
        cin = 1;
        #1 chk("grp8_8_c1", cout, 1);

        for (int i = 0; i < 512; i++) begin
            @(negedge clk) {a, b, cin} = i[8:0];
            e = 5'(a) + 5'(b) + 5'(cin);
            #1 chk("sweep_comb", {cout, sum}, e);
            chk("sweep_pg", pg, ((a ^ b) == 4'hf));
            chk("sweep_gg", gg, (5'(a) + 5'(b)) > 5'd15);
            @(posedge clk) #1 chk("sweep_reg", {cout_q, sum_q}, e);
        end

        @(negedge clk) a = 7; b = 7; cin = 0;
        #1 chk("mid_pre", {cout_q, sum_q}, 5'h1f);
        #1 rst = 1'b0;
        #1 chk("mid_async_drop", {cout_q, sum_q}, 0);
        @(posedge clk) #1 chk("mid_hold", {cout_q, sum_q}, 0);
        @(negedge clk) rst = 1'b1;
        #1 chk("mid_no_early", {cout_q, sum_q}, 0);
        @(posedge clk) #1 chk("mid_capture", {cout_q, sum_q}, 14);

        @(negedge clk) ca = 16'd40000; cb = 16'd40000; ccin = 1'b1;
        #1 chk("chain_80001", {ch[4], csum}, {1'b1, 16'd14465});
        ca = 16'd65535; cb = 16'd1; ccin = 1'b0;
        #1 chk("chain_wrap", {ch[4], csum}, {1'b1, 16'd0});
        ca = 16'h1234; cb = 16'h4321; ccin = 1'b0;
        #1 chk("chain_nocarry", {ch[4], csum}, {1'b0, 16'h5555});
        @(posedge clk) #1 chk("chain_regs", csq, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_4bit.md
Name: cla_4bit

Overview:
4-bit carry-lookahead adder slice used as the building block of the wider ALU adders.
- Combinational sum/carry outputs: allow four slices to be rippled through cin/cout in one cycle to form a 16-bit adder.
- Registered copies of sum/carry: give a 1-cycle pipelined result.
- Group propagate/generate outputs: support a second-level lookahead unit.

Parameters:
None. The width is fixed at 4 bits.

Ports:
clk  input  1  rising-edge clock for the registered outputs
rst  input  1  asynchronous, active-low reset
a  input  4  operand A (unsigned)
b  input  4  operand B (unsigned)
cin  input  1  carry in
sum  output  4  combinational sum, (a+b+cin)[3:0]
cout  output  1  combinational carry out, (a+b+cin)[4]
pg  output  1  group propagate
gg  output  1  group generate
sum_q  output  4  registered sum
cout_q  output  1  registered carry out

Behaviour:
- Per-bit terms: p[i] = a[i] ^ b[i]; g[i] = a[i] & b[i], for i = 0..3.
- Carries are computed in lookahead form, with no ripple between bits:
  - c0 = cin
  - c1 = g0 | p0&cin
  - c2 = g1 | p1&g0 | p1&p0&cin
  - c3 = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&cin
- Sum: sum[i] = p[i] ^ c[i].
- Group terms:
  - pg = p3&p2&p1&p0
  - gg = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0
  - cout = gg | pg&cin
- Combinational outputs (sum, cout, pg, gg):
  - Zero latency; pure functions of a, b, cin.
  - Independent of clk and rst; no internal state.
- {cout, sum} equals the 5-bit value a+b+cin for all 512 input combinations.
- Registered outputs:
  - On each rising clk with rst=1: sum_q <= sum, cout_q <= cout.
  - Latency is 1 cycle.
- Reset:
  - rst=0 forces sum_q=4'b0 and cout_q=0 immediately, without waiting for a clock edge.
  - Registers hold 0 while rst stays low.
  - The first capture happens on the first rising edge after rst returns high.
  - If reset is asserted mid-operation, the pending result is discarded.
- Overflow:
  - The result wraps modulo 16; the carry-out is the only overflow indication.
  - There is no saturation or signed-overflow flag.
- Chaining rule: a wider adder connects slice N's cout to slice N+1's cin using the combinational cout, never cout_q.
- No X propagation from reset into the combinational path.

Test Plan:
- Reset: hold rst=0 for 15 time units with toggling clock and a=9, b=9 -> sum_q=0, cout_q=0 throughout, while sum=2 and cout=1 combinationally.
- Directed adds, checking {cout,sum} immediately and {cout_q,sum_q} 1 cycle later:
  - a=14, b=1, cin=0 -> 15, cout 0
  - a=14, b=1, cin=1 -> 0, cout 1
  - a=15, b=1, cin=0 -> 0, cout 1
  - a=0, b=0, cin=1 -> 1, cout 0
- Group terms:
  - a=5, b=10 -> pg=1, gg=0; cout follows cin (cin=0 -> sum 15, cout 0; cin=1 -> sum 0, cout 1).
  - a=8, b=8 -> gg=1, pg=0, cout=1 for either cin.
- Exhaustive sweep of all 512 (a, b, cin) combinations -> {cout,sum} == a+b+cin every vector, and registered outputs match one cycle later.
- Reset mid-stream: apply a=7, b=7, then assert rst=0 between clock edges -> sum_q and cout_q drop to 0 asynchronously. Release rst -> sum_q=14, cout_q=0 after the next rising edge.
- Chaining check: four instances form a 16-bit adder using combinational cout -> the following results appear in one cycle:
  - 40000 + 40000 + 1 -> sum 14465, cout 1
  - 65535 + 1 -> sum 0, cout 1
